// File: rtl/oled_spi_monitor.sv
// Passive OLED SPI capture: deserializes bytes, tags them command/data and
// queues {dc, byte} in a FWFT FIFO. Reports link state, counters and errors.
//
// Ports:
//   sysclk, cpu_reset                    clock, sync active-high reset
//   oled_sclk/sdin/dc/res/vdd/vbat       observed OLED pins (never driven)
//   rd_en                                pop request
//   rd_data                              FIFO head {dc, byte}
//   empty, full, level                   FIFO status
//   overflow, frame_err                  sticky error flags
//   cmd_count, data_count                saturating byte counters
//   link_state                           0 OFF, 1 RESET, 2 ACTIVE
module oled_spi_monitor #(
  parameter int DEPTH        = 16,
  parameter int IDLE_TIMEOUT = 1024,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic          sysclk,
  input  logic          cpu_reset,
  input  logic          oled_sclk,
  input  logic          oled_sdin,
  input  logic          oled_dc,
  input  logic          oled_res,
  input  logic          oled_vdd,
  input  logic          oled_vbat,
  input  logic          rd_en,
  output logic [8:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          frame_err,
  output logic [15:0]   cmd_count,
  output logic [15:0]   data_count,
  output logic [1:0]    link_state
);

  typedef enum logic [1:0] {
    L_OFF    = 2'd0,
    L_RESET  = 2'd1,
    L_ACTIVE = 2'd2
  } link_e;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic sdin_s1, sdin_s2;
  logic dc_s1, dc_s2;
  logic res_s1, res_s2;
  logic vdd_s1, vdd_s2;
  logic vbat_s1, vbat_s2;
  logic unused_vbat;

  logic [6:0]  shreg;
  logic [2:0]  bitcnt;
  logic [15:0] idle;
  logic [AW:0] wptr, rptr;
  logic [8:0]  mem [DEPTH];

  link_e link;
  logic  active, rise, done, wr, pop, tmo;

  assign unused_vbat = vbat_s2;

  always_comb begin
    link = L_OFF;
    if (!vdd_s2) link = res_s2 ? L_ACTIVE : L_RESET;
  end

  assign link_state = link;
  assign active     = (link == L_ACTIVE);
  assign rise       = sclk_s2 & ~sclk_s3;
  assign done       = active & rise & (bitcnt == 3'd7);
  assign tmo        = (idle == 16'(IDLE_TIMEOUT - 1));

  assign level   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (level == (AW + 1)'(DEPTH));
  assign pop     = rd_en & ~empty;
  // A pop in the same cycle frees the slot even when full.
  assign wr      = done & (~full | pop);
  assign rd_data = empty ? 9'd0 : mem[rptr[AW-1:0]];

  always_ff @(posedge sysclk) begin
    if (cpu_reset) begin
      sclk_s1    <= 1'b1;
      sclk_s2    <= 1'b1;
      sclk_s3    <= 1'b1;
      sdin_s1    <= 1'b0;
      sdin_s2    <= 1'b0;
      dc_s1      <= 1'b0;
      dc_s2      <= 1'b0;
      res_s1     <= 1'b1;
      res_s2     <= 1'b1;
      vdd_s1     <= 1'b1;
      vdd_s2     <= 1'b1;
      vbat_s1    <= 1'b1;
      vbat_s2    <= 1'b1;
      shreg      <= '0;
      bitcnt     <= '0;
      idle       <= '0;
      wptr       <= '0;
      rptr       <= '0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
      cmd_count  <= '0;
      data_count <= '0;
    end else begin
      sclk_s1 <= oled_sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      sdin_s1 <= oled_sdin;
      sdin_s2 <= sdin_s1;
      dc_s1   <= oled_dc;
      dc_s2   <= dc_s1;
      res_s1  <= oled_res;
      res_s2  <= res_s1;
      vdd_s1  <= oled_vdd;
      vdd_s2  <= vdd_s1;
      vbat_s1 <= oled_vbat;
      vbat_s2 <= vbat_s1;

      if (!active) begin
        bitcnt <= '0;
        idle   <= '0;
      end else if (rise) begin
        shreg  <= {shreg[5:0], sdin_s2};
        bitcnt <= bitcnt + 3'd1;
        idle   <= '0;
      end else if (bitcnt != 3'd0) begin
        if (tmo) begin
          bitcnt    <= '0;
          idle      <= '0;
          frame_err <= 1'b1;
        end else begin
          idle <= idle + 16'd1;
        end
      end

      if (done) begin
        if (dc_s2) begin
          if (data_count != 16'hFFFF)
            data_count <= data_count + 16'd1;
        end else begin
          if (cmd_count != 16'hFFFF)
            cmd_count <= cmd_count + 16'd1;
        end
        if (!wr) overflow <= 1'b1;
      end

      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (wr) mem[wptr[AW-1:0]] <= {dc_s2, shreg, sdin_s2};
  end

endmodule

// File: tb/tb_oled_spi_monitor.sv
// Scoreboard bench for oled_spi_monitor: random SPI bytes, a queue model
// of the FIFO contents, and a monitor that checks every popped entry.
module tb_oled_spi_monitor;
  localparam int DEPTH = 16;
  localparam int TO    = 1024;

  logic        sysclk = 0;
  logic        cpu_reset = 1;
  logic        oled_sclk = 0, oled_sdin = 0, oled_dc = 0;
  logic        oled_res = 1, oled_vdd = 1, oled_vbat = 1;
  logic        rd_en = 0;
  logic [8:0]  rd_data;
  logic        empty, full, overflow, frame_err;
  logic [4:0]  level;
  logic [15:0] cmd_count, data_count;
  logic [1:0]  link_state;

  oled_spi_monitor #(.DEPTH(DEPTH), .IDLE_TIMEOUT(TO)) dut (
    .sysclk(sysclk), .cpu_reset(cpu_reset),
    .oled_sclk(oled_sclk), .oled_sdin(oled_sdin), .oled_dc(oled_dc),
    .oled_res(oled_res), .oled_vdd(oled_vdd), .oled_vbat(oled_vbat),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .level(level), .overflow(overflow), .frame_err(frame_err),
    .cmd_count(cmd_count), .data_count(data_count),
    .link_state(link_state)
  );

  always #5 sysclk = ~sysclk;

  int vectors = 0;
  int errors  = 0;
  logic [8:0] q[$];
  bit auto_pop = 0;
  bit pop_req  = 0;
  int exp_cmd = 0, exp_data = 0;
  bit exp_ovf = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops whenever asked and the DUT holds data.
  always @(negedge sysclk) begin
    if ((auto_pop || pop_req) && !empty && !cpu_reset) begin
      rd_en = 1;
      if (q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL pop: got %0h expected no entry", rd_data);
      end else begin
        check("pop", 32'(rd_data), 32'(q.pop_front()));
      end
    end else begin
      rd_en = 0;
    end
  end

  function automatic int link_of(logic vdd, logic res);
    return vdd ? 0 : (res ? 2 : 1);
  endfunction

  task automatic complete(logic [7:0] v, logic d);
    if (link_of(oled_vdd, oled_res) == 2) begin
      if (d) begin
        if (exp_data < 65535) exp_data++;
      end else begin
        if (exp_cmd < 65535) exp_cmd++;
      end
      if (q.size() < DEPTH) q.push_back({d, v});
      else exp_ovf = 1;
    end
  endtask

  task automatic send_bits(logic [7:0] v, int n, logic d,
                           bit pop_last = 0, bit lat = 0);
    for (int i = 0; i < n; i++) begin
      @(negedge sysclk);
      oled_sdin = v[7-i];
      oled_dc   = d;
      @(negedge sysclk);
      @(negedge sysclk);
      oled_sclk = 1;
      @(posedge sysclk);
      @(posedge sysclk);
      #1;
      if (i == 7) begin
        if (pop_last) pop_req = 1;
        if (lat) check("empty_E1", 32'(empty), 1);
      end
      @(posedge sysclk);
      #1;
      if (i == 7) begin
        pop_req = 0;
        complete(v, d);
        if (lat) check("empty_E2", 32'(empty), 0);
      end
      @(negedge sysclk);
      oled_sclk = 0;
      repeat (2) @(negedge sysclk);
    end
  endtask

  task automatic send_rand();
    logic [7:0] v;
    logic d;
    v = 8'($urandom);
    d = 1'($urandom);
    send_bits(v, 8, d);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_link"}, 32'(link_state), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_full"}, 32'(full), 0);
    check({tag, "_level"}, 32'(level), 0);
    check({tag, "_rd_data"}, 32'(rd_data), 0);
    check({tag, "_ovf"}, 32'(overflow), 0);
    check({tag, "_ferr"}, 32'(frame_err), 0);
    check({tag, "_cmd"}, 32'(cmd_count), 0);
    check({tag, "_data"}, 32'(data_count), 0);
  endtask

  task automatic do_reset(string tag);
    @(negedge sysclk);
    auto_pop  = 0;
    cpu_reset = 1;
    @(negedge sysclk);
    check_reset_outputs(tag);
    cpu_reset = 0;
    q.delete();
    exp_cmd  = 0;
    exp_data = 0;
    exp_ovf  = 0;
    repeat (4) @(negedge sysclk);
  endtask

  task automatic drain(string tag);
    auto_pop = 1;
    repeat (DEPTH + 4) @(negedge sysclk);
    auto_pop = 0;
    check({tag, "_drain_level"}, 32'(level), 0);
    check({tag, "_drain_empty"}, 32'(empty), 1);
  endtask

  task automatic check_counts(string tag);
    check({tag, "_cmd"}, 32'(cmd_count), 32'(exp_cmd));
    check({tag, "_data"}, 32'(data_count), 32'(exp_data));
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
  endtask

  initial begin
    repeat (3) @(negedge sysclk);
    check_reset_outputs("init");
    cpu_reset = 0;
    oled_vdd  = 0;
    repeat (4) @(negedge sysclk);
    check("link_active", 32'(link_state), 2);

    // Single command byte with latency check.
    send_bits(8'hAE, 8, 1'b0, 0, 1);
    check("ae_rd_data", 32'(rd_data), 32'h0AE);
    check("ae_level", 32'(level), 1);
    check("ae_cmd", 32'(cmd_count), 1);
    drain("ae");

    // Two data bytes popped in order.
    send_bits(8'h81, 8, 1'b1);
    send_bits(8'h7F, 8, 1'b1);
    check("two_level", 32'(level), 2);
    drain("two");
    check_counts("two");

    // Overflow with no pops.
    for (int i = 0; i < DEPTH + 1; i++) send_rand();
    check("ovf_full", 32'(full), 1);
    check("ovf_level", 32'(level), DEPTH);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_total", 32'(cmd_count + data_count),
          32'(exp_cmd + exp_data));
    drain("ovf");
    check_counts("ovf");

    // Pop coinciding with the write into a full FIFO.
    do_reset("rst1");
    for (int i = 0; i < DEPTH; i++) send_rand();
    check("full16", 32'(full), 1);
    send_bits(8'h5A, 8, 1'b1, 1);
    check("coinc_ovf", 32'(overflow), 0);
    check("coinc_level", 32'(level), DEPTH);
    check("coinc_full", 32'(full), 1);
    drain("coinc");
    check_counts("coinc");

    // Idle timeout on a partial byte.
    send_bits(8'hF0, 5, 1'b0);
    repeat (TO - 20) @(negedge sysclk);
    check("idle_early", 32'(frame_err), 0);
    repeat (40) @(negedge sysclk);
    check("idle_ferr", 32'(frame_err), 1);
    check("idle_level", 32'(level), 0);
    send_bits(8'hA5, 8, 1'b1);
    check("a5_level", 32'(level), 1);
    drain("a5");

    // Display reset aborts a partial byte silently.
    do_reset("rst2");
    send_bits(8'hC3, 4, 1'b0);
    @(negedge sysclk);
    oled_res = 0;
    repeat (4) @(negedge sysclk);
    check("res_link", 32'(link_state), 1);
    check("res_ferr", 32'(frame_err), 0);
    check("res_level", 32'(level), 0);
    oled_res = 1;
    repeat (4) @(negedge sysclk);
    check("res_link2", 32'(link_state), 2);
    send_bits(8'h3C, 8, 1'b0);
    check("3c_data", 32'(rd_data), 32'h03C);
    drain("3c");

    // Random traffic, random pop pressure.
    for (int i = 0; i < 40; i++) begin
      auto_pop = 1'($urandom_range(0, 3) == 0);
      send_rand();
    end
    auto_pop = 0;
    check("rand_level", 32'(level), 32'(q.size()));
    drain("rand");
    check_counts("rand");

    // Reset with entries queued and a byte in flight.
    for (int i = 0; i < 3; i++) send_rand();
    send_bits(8'h99, 4, 1'b1);
    check("pre_rst_level", 32'(level), 3);
    do_reset("rst3");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/oled_spi_monitor.md
# oled_spi_monitor

Passive capture block for the processor's OLED serial port: it observes `oled_sclk`, `oled_sdin`, `oled_dc`, `oled_res`, `oled_vdd` and `oled_vbat` exactly as driven to the display, deserializes each byte, tags it as command or data, and queues it in a small FIFO for a checker or host. It sits beside the processor in simulation and on-chip debug builds, acting as the display-side end of the interface. It never drives the OLED pins.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, 2..256
- `IDLE_TIMEOUT`, 1024, sysclk cycles without an SCLK rising edge before a partial byte is discarded; 2..65535
- `sysclk`  in  1  system clock; all logic is on its rising edge
- `cpu_reset`  in  1  synchronous, active-high reset
- `oled_sclk`, `oled_sdin`, `oled_dc`  in  1 each  serial clock, serial data, and data/command select (1 = data), as driven by the processor
- `oled_res`  in  1  display reset, active low
- `oled_vdd`, `oled_vbat`  in  1 each  logic and panel supply enables, active low
- `rd_en`  in  1  pop request; ignored while `empty`
- `rd_data`  out  9  FIFO head `{dc, byte[7:0]}`; valid while `!empty`
- `empty`, `full`  out  1 each  FIFO status
- `level`  out  $clog2(DEPTH)+1  number of entries held
- `overflow`  out  1  sticky; a completed byte was dropped because the FIFO was full
- `frame_err`  out  1  sticky; a partial byte was discarded on idle timeout
- `cmd_count`, `data_count`  out  16 each  completed bytes by type; saturate at 16'hFFFF
- `link_state`  out  2  0 = OFF, 1 = RESET, 2 = ACTIVE

## Operation
- Every OLED input passes through a 2-flop synchronizer. `sclk` has a third flop, and a rising edge is `s2 & ~s3`. `sdin` and `dc` are taken from the same stage as `s2`, so their alignment with `sclk` is preserved.
- Link state machine, re-evaluated every cycle from the synchronized inputs:
  - OFF when `vdd` = 1.
  - RESET when `vdd` = 0 and `res` = 0.
  - ACTIVE when `vdd` = 0 and `res` = 1.
  - Transitions take effect on the cycle the synchronized value changes. OFF→ACTIVE directly is legal.
- The shifter runs only in ACTIVE.
  - On each SCLK rising edge: `shreg <= {shreg[6:0], sdin}` (MSB first) and `bitcnt` increments.
  - When the 8th bit is shifted, the byte is completed with `dc` sampled on that same edge.
  - Then `bitcnt` returns to 0 and `cmd_count` (dc = 0) or `data_count` (dc = 1) increments, saturating.
- A completed byte is written to the FIFO unless the FIFO is full and not popped in the same cycle; in that case it is dropped and `overflow` is set. The byte is counted either way.
- Leaving ACTIVE clears `bitcnt` and the idle timer. The partial byte is silently discarded and `frame_err` is not set.
- Idle timer:
  - Counts cycles while `bitcnt != 0` and no SCLK rising edge occurs; an edge clears it.
  - On reaching `IDLE_TIMEOUT`, `bitcnt` and the timer clear and `frame_err` is set.
- FIFO:
  - First-word-fall-through, circular pointers one bit wider than the index.
  - `full` when `level == DEPTH`; pointers wrap modulo DEPTH.
  - Simultaneous write and pop is legal at any level, including full, and leaves `level` unchanged.
- `vbat` is synchronized but does not affect state in this revision.

## Timing
- Reset (`cpu_reset` high at a `sysclk` edge) clears:
  - all synchronizer flops to 1, except `sdin` and `dc` to 0;
  - `shreg`, `bitcnt`, idle timer, FIFO pointers, `overflow`, `frame_err`, both counters.
- Reset values of outputs:
  - `link_state` = 0 (OFF)
  - `empty` = 1, `full` = 0, `level` = 0
  - `rd_data` = 0
- Capture latency:
  - An SCLK rising edge with the pin stable across `sysclk` edge E0 is acted on at E2.
  - For the 8th bit, the FIFO write, counter increment and `empty` deassert all occur at E2.
- Pop: with `rd_en` = 1 and `!empty` at edge E, the head advances and `level` decrements at E. `rd_data` shows the next entry after E.
- Input constraint: SCLK high and low phases each last at least 3 `sysclk` periods, and `sdin`/`dc` are stable 2 periods before the SCLK rise. Violations are not detected.
- Reset has priority over every other event, including mid-byte and mid-pop.

## Test plan
- Reset, then ACTIVE, then shift 0xAE with dc = 0 -> `rd_data` = 9'h0AE, `level` = 1, `cmd_count` = 1, `empty` low exactly 2 cycles after the 8th SCLK rise.
- Send 0x81, 0x7F with dc = 1, then pop twice -> 9'h181 then 9'h17F, `data_count` = 2, `empty` = 1 after the second pop.
- Send DEPTH+1 bytes with no pops -> `full` = 1, `overflow` = 1, `level` = DEPTH, counters = DEPTH+1. Repeat with a pop in the same cycle as the 17th byte -> `overflow` stays 0.
- Send 5 bits, then hold SCLK for `IDLE_TIMEOUT` cycles -> `frame_err` = 1, nothing queued. A following full byte 0xA5 is captured correctly.
- Send 4 bits, then drive `res` low -> `link_state` = 1, partial byte discarded, `frame_err` = 0. Raise `res` and send 0x3C -> 9'h03C queued.
- Assert `cpu_reset` with 3 entries queued and a byte in flight -> all outputs return to their reset values on the next edge.
